// File: rtl/icache_direct_if.sv
// Fetch and memory-controller handshake bundle for the direct-mapped instruction cache.
// The slave view belongs to the cache; the master view belongs to the fetcher and memory controller.
interface icache_direct_if;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        flush;
    logic        mc_valid;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_inst;

    modport slave (
        input  if_req, if_pc, flush, mc_done, mc_inst,
        output if_valid, if_inst, mc_valid, mc_addr
    );

    modport master (
        output if_req, if_pc, flush, mc_done, mc_inst,
        input  if_valid, if_inst, mc_valid, mc_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache in front of the memory controller.
// Latency: hit returns 1 cycle after acceptance; miss returns memory latency + 1.
// Backpressure: rdy=0 freezes everything; a miss holds mc_valid/mc_addr until mc_done, even across flush.
module icache_direct #(
    parameter int INDEX_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    icache_direct_if.slave  bus
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   drop_q, drop_d;
    logic                   if_valid_q, if_valid_d;
    logic [31:0]            if_inst_q, if_inst_d;
    logic                   mc_valid_q, mc_valid_d;
    logic [31:0]            mc_addr_q, mc_addr_d;
    logic [INDEX_BITS-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;
    logic                   fill;

    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [31:0]            data_mem [LINES];
    logic [LINES-1:0]       line_vld;

    logic [INDEX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]    req_tag;
    logic                   hit;
    logic                   unused_pc_lsb;

    assign req_idx       = bus.if_pc[INDEX_BITS+1:2];
    assign req_tag       = bus.if_pc[31:INDEX_BITS+2];
    assign hit           = line_vld[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_pc_lsb = ^bus.if_pc[1:0];

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        if_valid_d = 1'b0;
        if_inst_d  = if_inst_q;
        mc_valid_d = mc_valid_q;
        mc_addr_d  = mc_addr_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        fill       = 1'b0;

        case (state_q)
            IDLE: begin
                // The cycle after a response pulse the fetcher may still hold if_req for the old pc.
                if (bus.if_req && !if_valid_q && !bus.flush) begin
                    if (hit) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = data_mem[req_idx];
                    end else begin
                        mc_valid_d = 1'b1;
                        mc_addr_d  = {bus.if_pc[31:2], 2'b00};
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        drop_d     = 1'b0;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                // The controller hangs if its request drops mid-read, so flush only marks the reply as dead.
                if (bus.flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mc_done) begin
                    fill       = 1'b1;
                    mc_valid_d = 1'b0;
                    state_d    = IDLE;
                    if (!drop_q && !bus.flush) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = bus.mc_inst;
                    end else begin
                        drop_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            mc_valid_q <= 1'b0;
            mc_addr_q  <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            mc_valid_q <= mc_valid_d;
            mc_addr_q  <= mc_addr_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_vld <= '0;
        end else if (rdy && fill) begin
            line_vld[miss_idx_q] <= 1'b1;
        end
    end

    // Tag/data contents are meaningless until their valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            tag_mem[miss_idx_q]  <= miss_tag_q;
            data_mem[miss_idx_q] <= bus.mc_inst;
        end
    end

    assign bus.if_valid = if_valid_q;
    assign bus.if_inst  = if_inst_q;
    assign bus.mc_valid = mc_valid_q;
    assign bus.mc_addr  = mc_addr_q;

endmodule
